// File: rtl/alu_rf_pipe.sv
// Two-stage integer pipeline: combinational register read/operand select feeding an
// EX register that retires RV32I-style ALU results into the register file.
// aluOp encoding: 2'd0 = TYPE_R, 2'd1 = TYPE_I, anything else is illegal.
module alu_rf_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned FORWARD_EN = 1,
  localparam int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            aluOp,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [ADDR_W-1:0]     rs1,
  input  logic [ADDR_W-1:0]     rs2,
  input  logic [ADDR_W-1:0]     rd,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_W-1:0]     out_rd,
  output logic                  out_Z,
  output logic                  out_overflow,
  output logic                  out_error,
  input  logic                  dbg_wen,
  input  logic [ADDR_W-1:0]     dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  input  logic [ADDR_W-1:0]     dbg_raddr,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam int unsigned MSB = DATA_WIDTH - 1;
  localparam logic [1:0] TYPE_R  = 2'd0;
  localparam logic [1:0] TYPE_I  = 2'd1;
  localparam logic [6:0] F7_ZERO = 7'd0;
  localparam logic [6:0] F7_ALT  = 7'd32;
  localparam bit         FWD     = (FORWARD_EN != 0);

  logic [DATA_WIDTH-1:0] rf [REG_COUNT];
  logic [DATA_WIDTH-1:0] rd1, rd2, op_a, op_b;
  logic [DATA_WIDTH-1:0] sum, diff, sll_v, srl_v, sra_v, slt_v, sltu_v;
  logic [DATA_WIDTH-1:0] alu_d;
  logic [SHW-1:0]        shamt;
  logic [6:0]            imm_f7;
  logic use_rs2, fwd_src, haz1, haz2, accept, retire, wr_en;
  logic add_ovf, sub_ovf, alu_ovf, alu_err, f7_zero;

  // imm[11:5] as seen by a sign-extended immediate, even for widths below 12
  if (DATA_WIDTH >= 12) begin : g_imm_wide
    assign imm_f7 = imm[11:5];
  end else begin : g_imm_narrow
    assign imm_f7 = {{(12 - DATA_WIDTH){imm[MSB]}}, imm[MSB:5]};
  end

  assign use_rs2 = (aluOp == TYPE_R);
  assign fwd_src = out_valid && (out_rd != '0) && !out_error;
  assign haz1    = fwd_src && (out_rd == rs1);
  assign haz2    = fwd_src && use_rs2 && (out_rd == rs2);
  assign in_ready = (!out_valid || out_ready) && !(!FWD && (haz1 || haz2));
  assign accept  = in_valid && in_ready;
  assign retire  = out_valid && out_ready;
  assign wr_en   = retire && (out_rd != '0) && !out_error;

  // RD stage: register read with optional bypass of the EX result
  always_comb begin
    rd1 = rf[rs1];
    rd2 = rf[rs2];
    if (FWD && haz1) rd1 = out_data;
    if (FWD && haz2) rd2 = out_data;
  end

  assign op_a    = rd1;
  assign op_b    = use_rs2 ? rd2 : imm;
  assign shamt   = op_b[SHW-1:0];
  assign sum     = op_a + op_b;
  assign diff    = op_a - op_b;
  assign sll_v   = op_a << shamt;
  assign srl_v   = op_a >> shamt;
  assign sra_v   = $unsigned($signed(op_a) >>> shamt);
  assign slt_v   = DATA_WIDTH'($signed(op_a) < $signed(op_b));
  assign sltu_v  = DATA_WIDTH'(op_a < op_b);
  assign add_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
  assign sub_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
  assign f7_zero = (funct7 == F7_ZERO);

  // ALU evaluated ahead of the EX register so every EX output is a flop
  always_comb begin
    alu_d   = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    if (aluOp == TYPE_R) begin
      case (funct3)
        3'd0: if (f7_zero) begin alu_d = sum; alu_ovf = add_ovf; end
              else if (funct7 == F7_ALT) begin alu_d = diff; alu_ovf = sub_ovf; end
              else alu_err = 1'b1;
        3'd1: if (f7_zero) alu_d = sll_v; else alu_err = 1'b1;
        3'd2: if (f7_zero) alu_d = slt_v; else alu_err = 1'b1;
        3'd3: if (f7_zero) alu_d = sltu_v; else alu_err = 1'b1;
        3'd4: if (f7_zero) alu_d = op_a ^ op_b; else alu_err = 1'b1;
        3'd5: if (f7_zero) alu_d = srl_v;
              else if (funct7 == F7_ALT) alu_d = sra_v;
              else alu_err = 1'b1;
        3'd6: if (f7_zero) alu_d = op_a | op_b; else alu_err = 1'b1;
        3'd7: if (f7_zero) alu_d = op_a & op_b; else alu_err = 1'b1;
      endcase
    end else if (aluOp == TYPE_I) begin
      case (funct3)
        3'd0: begin alu_d = sum; alu_ovf = add_ovf; end
        3'd1: if (imm_f7 == F7_ZERO) alu_d = sll_v; else alu_err = 1'b1;
        3'd2: alu_d = slt_v;
        3'd3: alu_d = sltu_v;
        3'd4: alu_d = op_a ^ op_b;
        3'd5: if (imm_f7 == F7_ZERO) alu_d = srl_v;
              else if (imm_f7 == F7_ALT) alu_d = sra_v;
              else alu_err = 1'b1;
        3'd6: alu_d = op_a | op_b;
        3'd7: alu_d = op_a & op_b;
      endcase
    end else begin
      alu_err = 1'b1;
    end
    if (alu_err) begin
      alu_d   = '0;
      alu_ovf = 1'b0;
    end
  end

  // EX register: holds its result until downstream takes it
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_rd       <= '0;
      out_Z        <= 1'b0;
      out_overflow <= 1'b0;
      out_error    <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_data     <= alu_d;
      out_rd       <= rd;
      out_Z        <= (alu_d == '0);
      out_overflow <= alu_ovf;
      out_error    <= alu_err;
    end else if (retire) begin
      out_valid    <= 1'b0;
    end
  end

  // Register file; retirement is written last so it wins over a debug write
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) rf[ADDR_W'(i)] <= '0;
    end else begin
      if (dbg_wen && (dbg_addr != '0)) rf[dbg_addr] <= dbg_data;
      if (wr_en) rf[out_rd] <= out_data;
    end
  end

  assign dbg_rdata = rf[dbg_raddr];

endmodule

// File: tb/tb_alu_rf_pipe.sv
// Bench for alu_rf_pipe: directed scenarios plus a randomized instruction stream
// compared against an arithmetic reference model of the architectural state.
module tb_alu_rf_pipe;

  localparam logic [1:0] OP_R = 2'd0;
  localparam logic [1:0] OP_I = 2'd1;

  logic        clk = 1'b0;
  logic        rstN;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  aluOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd, out_rd, dbg_addr, dbg_raddr;
  logic [31:0] imm, out_data, dbg_data, dbg_rdata;
  logic        out_Z, out_overflow, out_error, dbg_wen;

  logic        nf_iv, nf_in_ready, nf_out_valid, nf_Z, nf_ovf, nf_err;
  logic [4:0]  nf_out_rd;
  logic [31:0] nf_out_data, nf_dbg_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rf_m [32];
  logic        pend;

  always #5 clk = ~clk;

  alu_rf_pipe u_dut (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_Z(out_Z), .out_overflow(out_overflow), .out_error(out_error),
    .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  alu_rf_pipe #(.FORWARD_EN(0)) u_nf (
    .clk(clk), .rstN(rstN), .in_valid(nf_iv), .in_ready(nf_in_ready),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .out_valid(nf_out_valid), .out_ready(1'b1), .out_data(nf_out_data),
    .out_rd(nf_out_rd), .out_Z(nf_Z), .out_overflow(nf_ovf), .out_error(nf_err),
    .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(nf_dbg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result of one instruction, from the ISA rules in plain arithmetic
  function automatic void ref_alu(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] rb, input logic [31:0] im,
                                  output logic [31:0] d, output logic ovf, output logic err);
    logic [31:0] b;
    logic [6:0]  hi;
    longint      sa, sb, s;
    int          sh;
    b   = (op == OP_I) ? im : rb;
    hi  = im[11:5];
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = int'(b % 32);
    d   = 32'd0;
    ovf = 1'b0;
    err = 1'b0;
    s   = 0;
    if (op == OP_R) begin
      case (f3)
        3'd0: if (f7 == 7'd0 || f7 == 7'd32) begin
                s   = (f7 == 7'd0) ? sa + sb : sa - sb;
                d   = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
              end else err = 1'b1;
        3'd1: if (f7 == 7'd0) d = a << sh; else err = 1'b1;
        3'd2: if (f7 == 7'd0) d = (sa < sb) ? 32'd1 : 32'd0; else err = 1'b1;
        3'd3: if (f7 == 7'd0) d = (a < b) ? 32'd1 : 32'd0; else err = 1'b1;
        3'd4: if (f7 == 7'd0) d = a ^ b; else err = 1'b1;
        3'd5: if (f7 == 7'd0) d = a >> sh;
              else if (f7 == 7'd32) d = 32'(sa >>> sh);
              else err = 1'b1;
        3'd6: if (f7 == 7'd0) d = a | b; else err = 1'b1;
        3'd7: if (f7 == 7'd0) d = a & b; else err = 1'b1;
      endcase
    end else if (op == OP_I) begin
      case (f3)
        3'd0: begin
                s   = sa + sb;
                d   = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
              end
        3'd1: if (hi == 7'd0) d = a << sh; else err = 1'b1;
        3'd2: d = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: d = (a < b) ? 32'd1 : 32'd0;
        3'd4: d = a ^ b;
        3'd5: if (hi == 7'd0) d = a >> sh;
              else if (hi == 7'd32) d = 32'(sa >>> sh);
              else err = 1'b1;
        3'd6: d = a | b;
        3'd7: d = a & b;
      endcase
    end else begin
      err = 1'b1;
    end
    if (err) begin
      d   = 32'd0;
      ovf = 1'b0;
    end
  endfunction

  task automatic drain();
    if (pend) begin
      out_ready = 1'b1;
      tick();
      pend = 1'b0;
    end
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    drain();
    dbg_wen = 1'b1; dbg_addr = a; dbg_data = d;
    tick();
    dbg_wen = 1'b0;
    if (a != 5'd0) rf_m[a] = d;
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_raddr = a;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  // Offer one instruction, wait (bounded) for acceptance, then check the EX result
  task automatic issue(input string tag, input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdst,
                       input logic [31:0] im, input logic rdy);
    logic [31:0] ed;
    logic        eo, ee;
    int          n;
    ref_alu(op, f3, f7, rf_m[r1], rf_m[r2], im, ed, eo, ee);
    aluOp = op; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; rd = rdst; imm = im;
    out_ready = rdy;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(!pend || rdy));
    n = 0;
    while (!in_ready && n < 8) begin
      out_ready = 1'b1;
      tick();
      pend = 1'b0;
      out_ready = rdy;
      #1;
      n++;
    end
    if (n > 0) chk({tag, "_ready_after_retire"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    pend = 1'b1;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out_data"}, out_data, ed);
    chk({tag, "_out_rd"}, 32'(out_rd), 32'(rdst));
    chk({tag, "_out_Z"}, 32'(out_Z), 32'(ed == 32'd0));
    chk({tag, "_out_ovf"}, 32'(out_overflow), 32'(eo));
    chk({tag, "_out_err"}, 32'(out_error), 32'(ee));
    if (rdst != 5'd0 && !ee) rf_m[rdst] = ed;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old, im;
    logic [11:0] i12;
    logic [6:0]  f7;
    logic [4:0]  last_rd, r1, r2;
    logic [1:0]  op;
    int          k;

    rstN = 1'b0; in_valid = 1'b0; nf_iv = 1'b0; out_ready = 1'b1;
    aluOp = OP_R; funct3 = '0; funct7 = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    dbg_wen = 1'b0; dbg_addr = '0; dbg_data = '0; dbg_raddr = '0;
    pend = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;

    // Reset values
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_flags", {29'd0, out_Z, out_overflow, out_error}, 32'd0);
    rstN = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic add, then dependent add back-to-back through the bypass
    dbg_write(5'd10, 32'd5);
    dbg_write(5'd11, 32'd7);
    issue("add_x5", OP_R, 3'd0, 7'd0, 5'd10, 5'd11, 5'd5, 32'd0, 1'b1);
    chk("add_x5_const", out_data, 32'd12);
    issue("add_x6_fwd", OP_R, 3'd0, 7'd0, 5'd5, 5'd5, 5'd6, 32'd0, 1'b1);
    chk("add_x6_const", out_data, 32'd24);
    drain();
    peek("peek_x5", 5'd5, 32'd12);
    peek("peek_x6", 5'd6, 32'd24);

    // Same dependency on the non-forwarding instance: one stall cycle
    aluOp = OP_R; funct3 = 3'd0; funct7 = 7'd0; rs1 = 5'd10; rs2 = 5'd11; rd = 5'd5;
    nf_iv = 1'b1;
    #1;
    chk("nf_first_ready", 32'(nf_in_ready), 32'd1);
    tick();
    chk("nf_first_data", nf_out_data, 32'd12);
    rs1 = 5'd5; rs2 = 5'd5; rd = 5'd6;
    #1;
    chk("nf_stall_ready", 32'(nf_in_ready), 32'd0);
    tick();
    chk("nf_bubble_valid", 32'(nf_out_valid), 32'd0);
    chk("nf_resume_ready", 32'(nf_in_ready), 32'd1);
    tick();
    nf_iv = 1'b0;
    chk("nf_dep_data", nf_out_data, 32'd24);
    chk("nf_dep_rd", 32'(nf_out_rd), 32'd6);
    tick();

    // Overflow and zero flag
    dbg_write(5'd1, 32'h7FFF_FFFF);
    issue("addi_ovf", OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 32'd1, 1'b1);
    chk("addi_ovf_data", out_data, 32'h8000_0000);
    chk("addi_ovf_flag", 32'(out_overflow), 32'd1);
    issue("sub_zero", OP_R, 3'd0, 7'd32, 5'd1, 5'd1, 5'd3, 32'd0, 1'b1);
    chk("sub_zero_flag", 32'(out_Z), 32'd1);

    // Shifts and unsigned compare on the sign bit
    dbg_write(5'd1, 32'h8000_0000);
    issue("srai", OP_I, 3'd5, 7'd0, 5'd1, 5'd0, 5'd4, 32'h0000_0404, 1'b1);
    chk("srai_const", out_data, 32'hF800_0000);
    issue("srli", OP_I, 3'd5, 7'd0, 5'd1, 5'd0, 5'd4, 32'h0000_0004, 1'b1);
    chk("srli_const", out_data, 32'h0800_0000);
    issue("sltu", OP_R, 3'd3, 7'd0, 5'd1, 5'd0, 5'd7, 32'd0, 1'b1);
    chk("sltu_const", out_data, 32'd0);

    // Backpressure: result held for 3 cycles, no write until retirement
    drain();
    old = rf_m[8];
    issue("stall_add", OP_R, 3'd0, 7'd0, 5'd10, 5'd11, 5'd8, 32'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, 32'd12);
      chk("stall_rd", 32'(out_rd), 32'd8);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      peek("stall_no_write", 5'd8, old);
    end
    out_ready = 1'b1;
    tick();
    pend = 1'b0;
    peek("stall_written", 5'd8, 32'd12);

    // Write to x0 is discarded
    issue("add_x0", OP_R, 3'd0, 7'd0, 5'd10, 5'd11, 5'd0, 32'd0, 1'b1);
    drain();
    peek("x0_zero", 5'd0, 32'd0);

    // Illegal encoding leaves the destination alone
    dbg_write(5'd9, 32'h0000_0055);
    issue("illegal", OP_R, 3'd0, 7'd1, 5'd10, 5'd11, 5'd9, 32'd0, 1'b1);
    chk("illegal_err", 32'(out_error), 32'd1);
    chk("illegal_data", out_data, 32'd0);
    drain();
    peek("illegal_keep", 5'd9, 32'h0000_0055);

    // Debug write colliding with retirement: retirement wins
    issue("collide", OP_R, 3'd0, 7'd0, 5'd10, 5'd11, 5'd12, 32'd0, 1'b1);
    dbg_wen = 1'b1; dbg_addr = 5'd12; dbg_data = 32'hDEAD_BEEF;
    tick();
    dbg_wen = 1'b0;
    pend = 1'b0;
    peek("collide_retire_wins", 5'd12, 32'd12);

    // Reset in the middle of a stall drops the pending write
    issue("rst_pending", OP_R, 3'd0, 7'd0, 5'd10, 5'd11, 5'd13, 32'd0, 1'b0);
    tick();
    rstN = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    tick();
    rstN = 1'b1;
    out_ready = 1'b1;
    pend = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    tick();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    peek("midrst_x13", 5'd13, 32'd0);
    peek("midrst_x10", 5'd10, 32'd0);

    // Randomized stream with hazards and occasional backpressure
    dbg_write(5'd1, 32'h7FFF_FFFF);
    dbg_write(5'd2, 32'h8000_0000);
    dbg_write(5'd3, 32'hFFFF_FFFF);
    for (int r = 4; r < 32; r++) dbg_write(5'(r), $urandom);
    last_rd = 5'd1;
    for (int n = 0; n < 250; n++) begin
      k  = $urandom_range(0, 15);
      op = (k == 0) ? 2'(2 + $urandom_range(0, 1)) : ((k < 8) ? OP_R : OP_I);
      k  = $urandom_range(0, 9);
      f7 = (k < 5) ? 7'd0 : ((k < 9) ? 7'd32 : 7'($urandom));
      i12 = 12'($urandom);
      im  = 32'($urandom_range(0, 7));
      funct3 = im[2:0];
      if (funct3 == 3'd1 || funct3 == 3'd5) i12[11:5] = f7;
      im = {{20{i12[11]}}, i12};
      r1 = ($urandom_range(0, 2) == 0) ? last_rd : 5'($urandom);
      r2 = ($urandom_range(0, 2) == 0) ? last_rd : 5'($urandom);
      rd = 5'($urandom);
      last_rd = rd;
      issue("rand", op, funct3, f7, r1, r2, rd, im, ($urandom_range(0, 3) != 0));
    end
    drain();
    for (int r = 0; r < 32; r++) peek("final_rf", 5'(r), rf_m[r]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
